// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB-first.
// Operands enter over a valid/ready handshake, one difference bit is produced
// per clock using a borrow flip-flop, and the (WIDTH+1)-bit two's-complement
// result leaves over a second valid/ready handshake.
// Optional build macro SERIAL_SUB_SATURATE_EN: negative results (a < b) are
// presented as zero instead of the two's-complement value.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_diff;

  logic             w_bitDiff;
  logic             w_borrowNext;
  logic             w_lastBit;
  logic [WIDTH:0]   w_finalDiff;

  // One full-subtractor slice on the current LSBs plus the final-result assembly.
  always_comb begin
    w_bitDiff    = r_aShift[0] ^ r_bShift[0] ^ r_borrow;
    w_borrowNext = (~r_aShift[0] & r_bShift[0]) |
                   (~(r_aShift[0] ^ r_bShift[0]) & r_borrow);
    w_lastBit    = (r_count == CW'(WIDTH - 1));
`ifdef SERIAL_SUB_SATURATE_EN
    if (w_borrowNext) begin
      w_finalDiff = '0;
    end else begin
      w_finalDiff = {w_borrowNext, w_bitDiff, r_result[WIDTH-1:1]};
    end
`else
    w_finalDiff = {w_borrowNext, w_bitDiff, r_result[WIDTH-1:1]};
`endif
  end

  // State register; reset returns to IDLE and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_stateNext = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_lastBit) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Datapath: load operands in IDLE, shift one bit per CALC edge, latch the result on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aShift <= '0;
      r_bShift <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_aShift <= a;
            r_bShift <= b;
            r_borrow <= 1'b0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_aShift <= {1'b0, r_aShift[WIDTH-1:1]};
          r_bShift <= {1'b0, r_bShift[WIDTH-1:1]};
          r_result <= {w_bitDiff, r_result[WIDTH-1:1]};
          r_borrow <= w_borrowNext;
          r_count  <= r_count + CW'(1);
          if (w_lastBit) begin
            r_diff <= w_finalDiff;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = r_diff;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial sequential subtractor; the inverse counterpart of the combinational adder in the same arithmetic-exercise family.
- Accepts operands a and b over a valid/ready handshake and computes diff = a - b LSB-first, one bit per clock, using a borrow flip-flop.
- Presents the (WIDTH+1)-bit two's-complement result over an output valid/ready handshake.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff is valid.
- out_ready  input  1  consumer accepts diff.
- diff  output  WIDTH+1  a - b in two's complement; the MSB is the final borrow (sign).
- busy  output  1  high in CALC and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, internal shift registers, borrow and counter all 0.
- Reset mid-operation aborts the operation immediately. The next edge after rst deasserts behaves as IDLE; any partial result is discarded.
- State IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: capture a and b into shift registers, clear borrow and bit counter, go to CALC.
- State CALC:
  - in_ready=0, busy=1.
  - Each edge: d = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
  - Shift d into the result register from the MSB side; shift the a and b registers right; counter increments.
  - After the WIDTH-th CALC edge: go to DONE with diff = {brw_final, result}.
- State DONE:
  - out_valid=1, busy=1, in_ready=0.
  - diff is held stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
  - diff keeps its last value after the transfer; it is not cleared.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Minimum throughput: one operation per WIDTH+2 cycles. There is no accept in DONE, even if out_ready and in_valid are both high.
- Changes on a or b during CALC or DONE are ignored; in_valid outside IDLE is ignored and not queued.
- Arithmetic:
  - Result range is -(2^WIDTH - 1) .. 2^WIDTH - 1, always representable in WIDTH+1 bits, so no overflow is possible.
  - diff[WIDTH]=1 iff a < b.
- out_ready held high permanently: DONE lasts exactly one cycle.

Optional Feature:
- Macro: SERIAL_SUB_SATURATE_EN.
- Defined: when the final borrow is 1 (a < b), DONE presents diff=0 instead of the negative value. Timing and handshake are unchanged.
- Undefined: diff is the full two's-complement result as specified above.

Test Plan:
- Assert rst 2 cycles -> in_ready=1, out_valid=0, busy=0, diff=5'b00000.
- a=4'b0101, b=4'b0011, in_valid 1 cycle, out_ready=1 -> out_valid after 4 cycles, diff=5'b00010, then IDLE.
- a=4'b0011, b=4'b0101 -> diff=5'b11110 (-2); with SERIAL_SUB_SATURATE_EN defined -> diff=5'b00000.
- Boundaries:
  - a=15, b=15 -> 5'b00000.
  - a=15, b=0 -> 5'b01111.
  - a=0, b=15 -> 5'b10001.
- Backpressure: a=9, b=4, out_ready=0 for 3 cycles in DONE while in_valid=1 with a=1, b=1:
  - diff=5'b00101 held and out_valid held high; in_ready=0.
  - Second operand is not taken; after out_ready=1 the block returns to IDLE.
- Reset mid-CALC: start a=7, b=2, assert rst on the 2nd CALC cycle -> IDLE, out_valid never asserted; a following a=8, b=3 gives diff=5'b00101.
